// File: rtl/lfsr_src_pkg.sv
// Shared types and LFSR stepping for the handshake stimulus source.
package lfsr_src_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, PULSE, DONE} src_state_t;

    localparam int LFSR_W = 64;
    localparam int TAP_A  = 63;
    localparam int TAP_B  = 62;
    localparam int TAP_C  = 60;
    localparam int TAP_D  = 59;

    // x^64 + x^63 + x^61 + x^60 + 1, Fibonacci form, shifting left.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D]};
    endfunction

endpackage

// File: rtl/lfsr_handshake_source_lfsr64_core.sv
// 64-bit LFSR register; steps only when adv is high, zero seed maps to 1.
module lfsr64_core
    import lfsr_src_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [LFSR_W-1:0] seed,
    input  logic              adv,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] seed_fixed;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    assign seed_fixed = (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= seed_fixed;
        end else if (adv) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/lfsr_handshake_source.sv
// Request/ready stimulus source: answers a held want with a one-cycle ready
// pulse after LATENCY cycles, presenting a registered LFSR sample on data.
module lfsr_handshake_source
    import lfsr_src_pkg::*;
#(
    parameter int          WIDTH   = 32,
    parameter logic [63:0] SEED    = 64'h1,
    parameter int          LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             want,
    output logic             ready,
    output logic [WIDTH-1:0] data,
    output logic [15:0]      xfer_count,
    output logic             busy,
    output src_state_t       state_dbg
);

    // Handshake: the consumer raises want and holds it until it sees ready.
    // ready is high for exactly one cycle and data is valid in that cycle;
    // the transfer completes then even if want drops. A further request is
    // only accepted after want has been sampled low once.

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    src_state_t        state;
    logic [7:0]        cnt;
    logic [LFSR_W-1:0] lfsr_value;
    logic              lfsr_adv;

    assign lfsr_adv  = (state == PULSE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    lfsr64_core u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .adv   (lfsr_adv),
        .value (lfsr_value)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ready      <= 1'b0;
            data       <= '0;
            xfer_count <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (want) begin
                        cnt   <= CNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!want) begin
                        state <= IDLE;
                    end else if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        data  <= lfsr_value[WIDTH-1:0];
                        ready <= 1'b1;
                        state <= PULSE;
                    end
                end
                PULSE: begin
                    ready      <= 1'b0;
                    xfer_count <= xfer_count + 16'd1;
                    state      <= DONE;
                end
                DONE: begin
                    if (!want) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_handshake_source.sv
// Self-checking bench: three source configurations driven by directed and
// randomized request/abort sequences against a transaction-level model.
`timescale 1ns/1ps
module tb_lfsr_handshake_source;
    import lfsr_src_pkg::*;

    localparam int          LAT_A  = 2;
    localparam int          LAT_B  = 4;
    localparam int          LAT_W  = 1;
    localparam logic [63:0] SEED_A = 64'h1;
    localparam logic [63:0] SEED_B = 64'h1;
    localparam logic [63:0] SEED_W = 64'h8000_0000_0000_0000;
    localparam logic [63:0] POLY_MASK = (64'h1 << 63) | (64'h1 << 62) | (64'h1 << 60) | (64'h1 << 59);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v;
    logic [2:0]  want_v;
    logic [2:0]  ready_v;
    logic [2:0]  busy_v;
    logic [7:0]  data_a, data_b;
    logic [63:0] data_w;
    logic [15:0] cnt_a, cnt_b, cnt_w;
    src_state_t  st_a, st_b, st_w;

    lfsr_handshake_source #(.WIDTH(8), .SEED(SEED_A), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(rst_v[0]), .want(want_v[0]), .ready(ready_v[0]),
        .data(data_a), .xfer_count(cnt_a), .busy(busy_v[0]), .state_dbg(st_a)
    );
    lfsr_handshake_source #(.WIDTH(8), .SEED(SEED_B), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(rst_v[1]), .want(want_v[1]), .ready(ready_v[1]),
        .data(data_b), .xfer_count(cnt_b), .busy(busy_v[1]), .state_dbg(st_b)
    );
    lfsr_handshake_source #(.WIDTH(64), .SEED(SEED_W), .LATENCY(LAT_W)) dut_w (
        .clk(clk), .reset(rst_v[2]), .want(want_v[2]), .ready(ready_v[2]),
        .data(data_w), .xfer_count(cnt_w), .busy(busy_v[2]), .state_dbg(st_w)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model / scoreboard ----------------
    int          checks = 0;
    int          passed = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m_lfsr[3];
    logic [15:0] m_count[3];
    logic [63:0] m_data[3];

    function automatic logic [63:0] model_next(input logic [63:0] v);
        return (v << 1) | {63'h0, ^(v & POLY_MASK)};
    endfunction

    function automatic int lat_of(input int s);
        case (s)
            0:       return LAT_A;
            1:       return LAT_B;
            default: return LAT_W;
        endcase
    endfunction

    function automatic logic [63:0] seed_of(input int s);
        case (s)
            0:       return SEED_A;
            1:       return SEED_B;
            default: return SEED_W;
        endcase
    endfunction

    function automatic logic [63:0] mask_of(input int s);
        return (s == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFF;
    endfunction

    function automatic logic [63:0] obs_data(input int s);
        case (s)
            0:       return {56'h0, data_a};
            1:       return {56'h0, data_b};
            default: return data_w;
        endcase
    endfunction

    function automatic logic [15:0] obs_count(input int s);
        case (s)
            0:       return cnt_a;
            1:       return cnt_b;
            default: return cnt_w;
        endcase
    endfunction

    task automatic model_reset(input int s);
        m_lfsr[s]  = (seed_of(s) == 64'h0) ? 64'h1 : seed_of(s);
        m_count[s] = 16'h0;
        m_data[s]  = 64'h0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_idle(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", 64'(ready_v[s]), 64'h0);
            check("idle_busy", 64'(busy_v[s]), 64'h0);
        end
    endtask

    task automatic do_xfer(input int s, input int hold);
        int          n;
        logic        seen;
        logic [63:0] e;
        exp_q.push_back(m_lfsr[s] & mask_of(s));
        want_v[s] = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (ready_v[s]) seen = 1'b1;
        end
        check("ready_latency", 64'(n), 64'(lat_of(s) + 1));
        e = exp_q.pop_front();
        if (seen) begin
            check("xfer_data", obs_data(s), e);
            m_data[s]  = e;
            m_lfsr[s]  = model_next(m_lfsr[s]);
            m_count[s] = 16'(m_count[s] + 16'd1);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("no_second_pulse", 64'(ready_v[s]), 64'h0);
            check("done_busy", 64'(busy_v[s]), 64'h1);
            check("count_after_pulse", 64'(obs_count(s)), 64'(m_count[s]));
        end
        want_v[s] = 1'b0;
        @(negedge clk);
        check("ready_single", 64'(ready_v[s]), 64'h0);
        check("count_after_pulse", 64'(obs_count(s)), 64'(m_count[s]));
        @(negedge clk);
        check("xfer_count", 64'(obs_count(s)), 64'(m_count[s]));
        check("back_to_idle", 64'(busy_v[s]), 64'h0);
        check("data_held", obs_data(s), m_data[s]);
    endtask

    // k sampled cycles of want (1..LATENCY) is always short of a transfer.
    task automatic do_abort(input int s, input int k);
        want_v[s] = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check("abort_no_ready", 64'(ready_v[s]), 64'h0);
        end
        want_v[s] = 1'b0;
        @(negedge clk);
        check("abort_no_ready", 64'(ready_v[s]), 64'h0);
        @(negedge clk);
        check("abort_busy", 64'(busy_v[s]), 64'h0);
        check("abort_count", 64'(obs_count(s)), 64'(m_count[s]));
        check("abort_data", obs_data(s), m_data[s]);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int   n;
        logic seen;
        rst_v  = 3'b000;
        want_v = 3'b000;
        for (int s = 0; s < 3; s++) model_reset(s);
        repeat (3) @(negedge clk);

        for (int s = 0; s < 3; s++) begin
            check("rst_ready", 64'(ready_v[s]), 64'h0);
            check("rst_data", obs_data(s), 64'h0);
            check("rst_busy", 64'(busy_v[s]), 64'h0);
            check("rst_count", 64'(obs_count(s)), 64'h0);
        end
        check("rst_state_a", 64'(st_a), 64'(IDLE));
        check("rst_state_b", 64'(st_b), 64'(IDLE));
        check("rst_state_w", 64'(st_w), 64'(IDLE));

        rst_v = 3'b111;
        repeat (10) begin
            @(negedge clk);
            check("idle_ready", 64'(ready_v[0]), 64'h0);
            check("idle_data", obs_data(0), 64'h0);
            check("idle_busy", 64'(busy_v[0]), 64'h0);
            check("idle_count", 64'(obs_count(0)), 64'h0);
        end

        // Basic transfer with want held afterwards, then a short sequence.
        do_xfer(0, 4);
        check("basic_data", obs_data(0), 64'h01);
        check("basic_count", 64'(obs_count(0)), 64'h1);
        do_xfer(0, 0);
        check("seq_data2", obs_data(0), 64'h02);
        do_xfer(0, 0);
        check("seq_data3", obs_data(0), 64'h04);
        check("seq_count", 64'(obs_count(0)), 64'h3);

        // Random mix of completed requests, aborts and idle gaps.
        repeat (24) begin
            if ($urandom_range(0, 3) == 0) do_abort(0, $urandom_range(1, LAT_A));
            else                           do_xfer(0, $urandom_range(0, 3));
            do_idle(0, $urandom_range(0, 2));
        end

        // Abort on the long-latency source, then a full request.
        do_abort(1, 2);
        check("abort_data_zero", obs_data(1), 64'h0);
        check("abort_count_zero", 64'(obs_count(1)), 64'h0);
        repeat (3) begin
            do_abort(1, $urandom_range(1, LAT_B));
        end
        do_xfer(1, 1);
        check("after_abort_data", obs_data(1), 64'h01);

        // Reset asserted during the ready pulse.
        want_v[1] = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (ready_v[1]) seen = 1'b1;
        end
        check("midflight_pulse_seen", 64'(seen), 64'h1);
        rst_v[1] = 1'b0;
        #1;
        check("midflight_ready", 64'(ready_v[1]), 64'h0);
        check("midflight_data", obs_data(1), 64'h0);
        check("midflight_busy", 64'(busy_v[1]), 64'h0);
        check("midflight_count", 64'(obs_count(1)), 64'h0);
        want_v[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_v[1] = 1'b1;
        model_reset(1);
        do_idle(1, 1);
        do_xfer(1, 0);
        check("post_reset_data", obs_data(1), 64'h01);

        // Full-width source and transfer counter wrap.
        do_xfer(2, 0);
        check("wide_first_data", obs_data(2), 64'h8000_0000_0000_0000);
        force dut_w.xfer_count = 16'hFFFF;
        @(negedge clk);
        release dut_w.xfer_count;
        m_count[2] = 16'hFFFF;
        do_idle(2, 1);
        check("preload_count", 64'(obs_count(2)), 64'hFFFF);
        do_xfer(2, 1);
        check("wide_second_data", obs_data(2), 64'h0000_0000_0000_0001);
        check("wrap_count", 64'(obs_count(2)), 64'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
